// File: rtl/ps2_cmd_sched.sv
// ps2_cmd_sched: arbitrates one ps2_host between two command requesters
// (0 = power-on init, 1 = bus/software) and runs each command byte through
// transmit -> wait for 0xFA / resend on 0xFE -> status report. Device bytes
// that are not ACK/RESEND are forwarded on the rx stream port.
//
// Optional build macro: PS2_SCHED_TIMEOUT_EN adds a response timeout of
// CLK_FREQ*1000*TIMEOUT_MS cycles (status 3). Without it a silent device
// holds the scheduler in WAIT until reset.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid[1:0], req_data[15:0]  per-requester command pending / {byte1, byte0}
//   req_grant[1:0]                  one-hot owner of the host
//   req_done[1:0], req_status[1:0]  completion pulse + status (0 ok, 1 retry, 2 err, 3 timeout)
//   rx_valid, rx_data, rx_perr      forwarded device byte stream
//   host_tx_en, host_tx_data        transmit request to ps2_host
//   host_rx_en                      receive enable to ps2_host
//   host_rx_data, host_*_busy/ack/err  status from ps2_host
module ps2_cmd_sched #(
    parameter int unsigned CLK_FREQ   = 100,
    parameter int unsigned TIMEOUT_MS = 20,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    output logic [1:0]  req_grant,
    output logic [1:0]  req_done,
    output logic [1:0]  req_status,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_perr,
    output logic        host_tx_en,
    output logic [7:0]  host_tx_data,
    output logic        host_rx_en,
    input  logic [7:0]  host_rx_data,
    input  logic        host_tx_busy,
    input  logic        host_rx_busy,
    input  logic        host_tx_ack,
    input  logic        host_rx_ack,
    input  logic        host_tx_err,
    input  logic        host_rx_err
);

    localparam int unsigned RETRY_W   = 4;
    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;
    localparam logic [1:0] STS_OK      = 2'd0;
    localparam logic [1:0] STS_RETRY   = 2'd1;
    localparam logic [1:0] STS_ERR     = 2'd2;

    // Elaboration-time sanity check of the configuration
    if (CLK_FREQ * TIMEOUT_MS == 0 || MAX_RETRY > 15) begin : g_cfg_chk
        $error("ps2_cmd_sched: invalid CLK_FREQ/TIMEOUT_MS/MAX_RETRY");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 last_grant_q, last_grant_d;
    logic [1:0]           done_q, done_d;
    logic [1:0]           status_q, status_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 tx_en_q, tx_en_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 rx_en_q, rx_en_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 pick_c;

    // The host's transmit busy flag is implied by SEND; not needed here
    logic unused_tx_busy_c;
    assign unused_tx_busy_c = host_tx_busy;

`ifdef PS2_SCHED_TIMEOUT_EN
    localparam logic [1:0]  STS_TIMEOUT = 2'd3;
    localparam int unsigned TO_CYCLES   = CLK_FREQ * 1000 * TIMEOUT_MS;
    localparam int unsigned TO_W        = $clog2(TO_CYCLES);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_expired_c;
    assign to_expired_c = (to_cnt_q == TO_W'(TO_CYCLES - 1));
`endif

    // Next-state, arbitration, retry and forwarding logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        done_d       = 2'b00;
        status_d     = status_q;
        rx_valid_d   = 1'b0;
        rx_data_d    = rx_data_q;
        rx_perr_d    = rx_perr_q;
        tx_data_d    = tx_data_q;
        retry_d      = retry_q;
        pick_c       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (host_rx_ack || host_rx_err) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = host_rx_data;
                    rx_perr_d  = host_rx_err;
                end
                // Never start a command while the host is mid-way through a receive
                if (|req_valid && !host_rx_busy) begin
                    pick_c    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
                    grant_d   = pick_c ? 2'b10 : 2'b01;
                    tx_data_d = pick_c ? req_data[15:8] : req_data[7:0];
                    retry_d   = '0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (host_tx_err) begin
                    status_d = STS_ERR;
                    state_d  = ST_DONE;
                end else if (host_tx_ack) begin
                    state_d = ST_WAIT;
                end
`ifdef PS2_SCHED_TIMEOUT_EN
                else if (to_expired_c) begin
                    status_d = STS_TIMEOUT;
                    state_d  = ST_DONE;
                end
`endif
            end
            ST_WAIT: begin
                // rx_err wins over a simultaneous rx_ack
                if (host_rx_err) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = host_rx_data;
                    rx_perr_d  = 1'b1;
                    status_d   = STS_ERR;
                    state_d    = ST_DONE;
                end else if (host_rx_ack) begin
                    if (host_rx_data == BYTE_ACK) begin
                        status_d = STS_OK;
                        state_d  = ST_DONE;
                    end else if (host_rx_data == BYTE_RESEND) begin
                        if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = ST_SEND;
                        end else begin
                            status_d = STS_RETRY;
                            state_d  = ST_DONE;
                        end
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = host_rx_data;
                        rx_perr_d  = 1'b0;
                    end
                end
`ifdef PS2_SCHED_TIMEOUT_EN
                else if (to_expired_c) begin
                    status_d = STS_TIMEOUT;
                    state_d  = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                last_grant_d = grant_q[1];
                grant_d      = 2'b00;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Completion pulse coincides with the single DONE cycle
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            done_d = grant_q;
        end

        tx_en_d = (state_d == ST_SEND);
        // Dropping rx_en for the DONE cycle re-arms the host receiver
        rx_en_d = (state_d != ST_DONE);

`ifdef PS2_SCHED_TIMEOUT_EN
        if ((state_d == ST_SEND || state_d == ST_WAIT) && state_d == state_q && !host_rx_ack) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = '0;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            done_q       <= 2'b00;
            status_q     <= 2'b00;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_perr_q    <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_data_q    <= 8'h00;
            rx_en_q      <= 1'b0;
            retry_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            done_q       <= done_d;
            status_q     <= status_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            rx_perr_q    <= rx_perr_d;
            tx_en_q      <= tx_en_d;
            tx_data_q    <= tx_data_d;
            rx_en_q      <= rx_en_d;
            retry_q      <= retry_d;
        end
    end

`ifdef PS2_SCHED_TIMEOUT_EN
    // Response timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign req_grant    = grant_q;
    assign req_done     = done_q;
    assign req_status   = status_q;
    assign rx_valid     = rx_valid_q;
    assign rx_data      = rx_data_q;
    assign rx_perr      = rx_perr_q;
    assign host_tx_en   = tx_en_q;
    assign host_tx_data = tx_data_q;
    assign host_rx_en   = rx_en_q;

endmodule
